// File: rtl/mem_port_arbiter.sv
// Two-to-one arbiter for the shared memory port used by instruction fetch and data.
// Grants are tracked in an in-order owner FIFO so each response returns to its issuer.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned MAX_OUTST = 4,
    parameter int unsigned DATA_PRIO = 0
) (
    input  logic                         clk,
    input  logic                         arst_n,
    input  logic                         inst_req,
    input  logic [ADDR_W-1:0]            inst_addr,
    output logic                         inst_gnt,
    output logic                         inst_rvalid,
    output logic [DATA_W-1:0]            inst_rdata,
    input  logic                         data_req,
    input  logic [ADDR_W-1:0]            data_addr,
    input  logic                         data_we,
    input  logic [DATA_W/8-1:0]          data_be,
    input  logic [DATA_W-1:0]            data_wdata,
    output logic                         data_gnt,
    output logic                         data_rvalid,
    output logic [DATA_W-1:0]            data_rdata,
    output logic                         mem_req,
    output logic [ADDR_W-1:0]            mem_addr,
    output logic                         mem_we,
    output logic [DATA_W/8-1:0]          mem_be,
    output logic [DATA_W-1:0]            mem_wdata,
    input  logic                         mem_gnt,
    input  logic                         mem_rvalid,
    input  logic [DATA_W-1:0]            mem_rdata,
    output logic [$clog2(MAX_OUTST):0]   outst_cnt,
    output logic                         resp_err
);

    localparam int unsigned BE_W  = DATA_W / 8;
    localparam int unsigned PTR_W = $clog2(MAX_OUTST);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic {
        OWN_INST = 1'b0,
        OWN_DATA = 1'b1
    } owner_e;

    owner_e             fifo [MAX_OUTST];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   cnt;
    owner_e             last_gnt;
    logic               lock;
    owner_e             lock_sel;

    owner_e             sel;
    owner_e             head;
    logic               full;
    logic               empty;
    logic               push;
    logic               pop;

    assign full  = (cnt == CNT_W'(MAX_OUTST));
    assign empty = (cnt == '0);

    // A stalled request keeps its owner; otherwise pick by priority or fairness.
    always_comb begin
        sel = OWN_INST;
        if (lock) begin
            sel = lock_sel;
        end else if (inst_req && data_req) begin
            if (DATA_PRIO != 0) begin
                sel = OWN_DATA;
            end else begin
                sel = (last_gnt == OWN_DATA) ? OWN_INST : OWN_DATA;
            end
        end else if (data_req) begin
            sel = OWN_DATA;
        end
    end

    // Request mux; instruction side is always a full-word read.
    always_comb begin
        mem_req = arst_n & ~full & ((sel == OWN_DATA) ? data_req : inst_req);
        if (sel == OWN_DATA) begin
            mem_addr  = data_addr;
            mem_we    = data_we;
            mem_be    = data_be;
            mem_wdata = data_wdata;
        end else begin
            mem_addr  = inst_addr;
            mem_we    = 1'b0;
            mem_be    = {BE_W{1'b1}};
            mem_wdata = '0;
        end
    end

    assign push     = mem_req & mem_gnt;
    assign inst_gnt = push & (sel == OWN_INST);
    assign data_gnt = push & (sel == OWN_DATA);

    // Responses with nothing outstanding are dropped and flagged instead of routed.
    assign head        = fifo[rd_ptr];
    assign pop         = arst_n & mem_rvalid & ~empty;
    assign inst_rvalid = pop & (head == OWN_INST);
    assign data_rvalid = pop & (head == OWN_DATA);
    assign inst_rdata  = mem_rdata;
    assign data_rdata  = mem_rdata;
    assign outst_cnt   = cnt;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            for (int i = 0; i < int'(MAX_OUTST); i++) begin
                fifo[i] <= OWN_INST;
            end
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            cnt      <= '0;
            last_gnt <= OWN_DATA;
            lock     <= 1'b0;
            lock_sel <= OWN_INST;
            resp_err <= 1'b0;
        end else begin
            if (push) begin
                fifo[wr_ptr] <= sel;
                wr_ptr       <= wr_ptr + PTR_W'(1);
                last_gnt     <= sel;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
            if (mem_req) begin
                lock     <= ~mem_gnt;
                lock_sel <= sel;
            end
            if (mem_rvalid && empty) begin
                resp_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: grant/response scoreboard on a round-robin
// instance, plus direct checks on a data-priority instance.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        arst_n;
    logic        inst_req, inst_gnt, inst_rvalid;
    logic [31:0] inst_addr, inst_rdata;
    logic        data_req, data_we, data_gnt, data_rvalid;
    logic [31:0] data_addr, data_wdata, data_rdata;
    logic [3:0]  data_be;
    logic        mem_req, mem_we, mem_gnt, mem_rvalid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;
    logic [2:0]  outst_cnt;
    logic        resp_err;

    logic        p_inst_req, p_inst_gnt, p_inst_rvalid;
    logic [31:0] p_inst_addr, p_inst_rdata;
    logic        p_data_req, p_data_we, p_data_gnt, p_data_rvalid;
    logic [31:0] p_data_addr, p_data_wdata, p_data_rdata;
    logic [3:0]  p_data_be;
    logic        p_mem_req, p_mem_we, p_mem_gnt, p_mem_rvalid;
    logic [31:0] p_mem_addr, p_mem_wdata, p_mem_rdata;
    logic [3:0]  p_mem_be;
    logic [2:0]  p_outst_cnt;
    logic        p_resp_err;

    int n_vec = 0;
    int n_err = 0;
    logic [32:0] exp_gnt[$];
    logic [32:0] exp_rsp[$];

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_OUTST(4), .DATA_PRIO(0)) dut (
        .clk(clk), .arst_n(arst_n),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_gnt(inst_gnt),
        .inst_rvalid(inst_rvalid), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_addr(data_addr), .data_we(data_we), .data_be(data_be),
        .data_wdata(data_wdata), .data_gnt(data_gnt), .data_rvalid(data_rvalid),
        .data_rdata(data_rdata),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_we(mem_we), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata), .outst_cnt(outst_cnt), .resp_err(resp_err)
    );

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_OUTST(4), .DATA_PRIO(1)) dut_prio (
        .clk(clk), .arst_n(arst_n),
        .inst_req(p_inst_req), .inst_addr(p_inst_addr), .inst_gnt(p_inst_gnt),
        .inst_rvalid(p_inst_rvalid), .inst_rdata(p_inst_rdata),
        .data_req(p_data_req), .data_addr(p_data_addr), .data_we(p_data_we),
        .data_be(p_data_be), .data_wdata(p_data_wdata), .data_gnt(p_data_gnt),
        .data_rvalid(p_data_rvalid), .data_rdata(p_data_rdata),
        .mem_req(p_mem_req), .mem_addr(p_mem_addr), .mem_we(p_mem_we), .mem_be(p_mem_be),
        .mem_wdata(p_mem_wdata), .mem_gnt(p_mem_gnt), .mem_rvalid(p_mem_rvalid),
        .mem_rdata(p_mem_rdata), .outst_cnt(p_outst_cnt), .resp_err(p_resp_err)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every grant and every response must match the head of its queue.
    always @(negedge clk) begin
        if (arst_n === 1'b1) begin
            if (inst_gnt || data_gnt) begin
                if (exp_gnt.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_gnt: got inst=%0b data=%0b, want none (t=%0t)",
                             inst_gnt, data_gnt, $time);
                end else begin
                    logic [32:0] e;
                    e = exp_gnt.pop_front();
                    chk("gnt_owner", {63'd0, data_gnt}, {63'd0, e[32]});
                    chk("gnt_onehot", {63'd0, inst_gnt & data_gnt}, 64'd0);
                    chk("gnt_addr", {32'd0, mem_addr}, {32'd0, e[31:0]});
                end
            end
            if (inst_rvalid || data_rvalid) begin
                if (exp_rsp.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_rvalid: got inst=%0b data=%0b, want none (t=%0t)",
                             inst_rvalid, data_rvalid, $time);
                end else begin
                    logic [32:0] e;
                    e = exp_rsp.pop_front();
                    chk("rsp_owner", {62'd0, inst_rvalid, data_rvalid},
                        {62'd0, ~e[32], e[32]});
                    chk("rsp_data", {32'd0, e[32] ? data_rdata : inst_rdata}, {32'd0, e[31:0]});
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        arst_n = 1'b0;
        {inst_req, data_req, data_we, mem_gnt, mem_rvalid} = '0;
        inst_addr = '0; data_addr = '0; data_be = '0; data_wdata = '0; mem_rdata = '0;
        {p_inst_req, p_data_req, p_data_we, p_mem_gnt, p_mem_rvalid} = '0;
        p_inst_addr = 32'h700; p_data_addr = 32'h600; p_data_be = 4'h5;
        p_data_wdata = '0; p_mem_rdata = '0;

        // Reset holds all request/grant outputs low even with a request present.
        inst_req = 1'b1; inst_addr = 32'h100; mem_gnt = 1'b1;
        #3;
        chk("rst_mem_req", {63'd0, mem_req}, 64'd0);
        chk("rst_inst_gnt", {63'd0, inst_gnt}, 64'd0);
        chk("rst_cnt", {61'd0, outst_cnt}, 64'd0);
        chk("rst_resp_err", {63'd0, resp_err}, 64'd0);

        // Single instruction read and its response.
        repeat (2) @(posedge clk);
        #1;
        arst_n = 1'b1;
        exp_gnt.push_back({1'b0, 32'h100});
        #2;
        chk("t1_mem_req", {63'd0, mem_req}, 64'd1);
        chk("t1_mem_addr", {32'd0, mem_addr}, 64'h100);
        chk("t1_mem_we", {63'd0, mem_we}, 64'd0);
        chk("t1_mem_be", {60'd0, mem_be}, 64'hF);
        next_cyc();
        inst_req = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hDEADBEEF;
        exp_rsp.push_back({1'b0, 32'hDEADBEEF});
        #2;
        chk("t1_cnt_after_gnt", {61'd0, outst_cnt}, 64'd1);
        chk("t1_inst_rvalid", {63'd0, inst_rvalid}, 64'd1);
        chk("t1_data_rvalid", {63'd0, data_rvalid}, 64'd0);
        next_cyc();
        mem_rvalid = 1'b0;
        #2;
        chk("t1_cnt_after_rsp", {61'd0, outst_cnt}, 64'd0);

        // Fresh reset so instruction wins the first tie; then round-robin to full.
        arst_n = 1'b0;
        #2;
        arst_n = 1'b1;
        next_cyc();
        for (int i = 0; i < 4; i++) begin
            inst_req = 1'b1; inst_addr = 32'h200;
            data_req = 1'b1; data_addr = 32'h300; data_we = 1'b0; data_be = 4'hC;
            mem_gnt = 1'b1;
            exp_gnt.push_back(i[0] ? {1'b1, 32'h300} : {1'b0, 32'h200});
            #2;
            chk("rr_cnt", {61'd0, outst_cnt}, 64'(i));
            next_cyc();
        end
        #2;
        chk("full_cnt", {61'd0, outst_cnt}, 64'd4);
        chk("full_mem_req", {63'd0, mem_req}, 64'd0);
        next_cyc();
        mem_rvalid = 1'b1; mem_rdata = 32'hA1;
        exp_rsp.push_back({1'b0, 32'hA1});
        #2;
        chk("full_pop_mem_req", {63'd0, mem_req}, 64'd0);
        next_cyc();
        mem_rvalid = 1'b0;
        exp_gnt.push_back({1'b0, 32'h200});
        #2;
        chk("pop_cnt", {61'd0, outst_cnt}, 64'd3);
        chk("retry_mem_req", {63'd0, mem_req}, 64'd1);
        next_cyc();
        inst_req = 1'b0; data_req = 1'b0; mem_gnt = 1'b0;
        for (int i = 0; i < 4; i++) begin
            mem_rvalid = 1'b1; mem_rdata = 32'hA2 + 32'(i);
            exp_rsp.push_back({~i[0], 32'hA2 + 32'(i)});
            #2;
            if (i == 0) chk("refill_cnt", {61'd0, outst_cnt}, 64'd4);
            next_cyc();
        end
        mem_rvalid = 1'b0;
        #2;
        chk("drain_cnt", {61'd0, outst_cnt}, 64'd0);
        next_cyc();

        // Lock: a stalled instruction request stays selected while data arrives.
        inst_req = 1'b1; inst_addr = 32'h400; mem_gnt = 1'b0;
        #2;
        chk("lock_a_addr", {32'd0, mem_addr}, 64'h400);
        next_cyc();
        data_req = 1'b1; data_addr = 32'h500; data_we = 1'b1; data_be = 4'h3;
        data_wdata = 32'h55;
        for (int i = 0; i < 2; i++) begin
            #2;
            chk("lock_hold_addr", {32'd0, mem_addr}, 64'h400);
            chk("lock_hold_we", {63'd0, mem_we}, 64'd0);
            next_cyc();
        end
        mem_gnt = 1'b1;
        exp_gnt.push_back({1'b0, 32'h400});
        #2;
        chk("lock_rel_addr", {32'd0, mem_addr}, 64'h400);
        next_cyc();
        inst_addr = 32'h404;
        exp_gnt.push_back({1'b1, 32'h500});
        #2;
        chk("wr_mem_we", {63'd0, mem_we}, 64'd1);
        chk("wr_mem_be", {60'd0, mem_be}, 64'h3);
        chk("wr_mem_wdata", {32'd0, mem_wdata}, 64'h55);
        next_cyc();
        inst_req = 1'b0; data_req = 1'b0; data_we = 1'b0; mem_gnt = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 32'h11;
        exp_rsp.push_back({1'b0, 32'h11});
        next_cyc();
        mem_rdata = 32'h22;
        exp_rsp.push_back({1'b1, 32'h22});
        next_cyc();
        mem_rvalid = 1'b0;
        #2;
        chk("lock_drain_cnt", {61'd0, outst_cnt}, 64'd0);
        next_cyc();

        // Stray response with nothing outstanding.
        mem_rvalid = 1'b1; mem_rdata = 32'h99;
        #2;
        chk("stray_inst_rvalid", {63'd0, inst_rvalid}, 64'd0);
        chk("stray_data_rvalid", {63'd0, data_rvalid}, 64'd0);
        chk("stray_err_pre", {63'd0, resp_err}, 64'd0);
        next_cyc();
        mem_rvalid = 1'b0;
        #2;
        chk("stray_err_set", {63'd0, resp_err}, 64'd1);
        chk("stray_cnt", {61'd0, outst_cnt}, 64'd0);
        repeat (3) next_cyc();
        chk("stray_err_sticky", {63'd0, resp_err}, 64'd1);
        arst_n = 1'b0;
        #2;
        chk("stray_err_cleared", {63'd0, resp_err}, 64'd0);
        arst_n = 1'b1;
        next_cyc();

        // Data-priority instance: data wins every tie until it drops.
        for (int i = 0; i < 4; i++) begin
            p_inst_req = 1'b1; p_data_req = 1'b1; p_mem_gnt = 1'b1;
            p_mem_rvalid = (i > 0); p_mem_rdata = 32'hB0 + 32'(i);
            #2;
            chk("prio_data_gnt", {63'd0, p_data_gnt}, 64'd1);
            chk("prio_inst_gnt", {63'd0, p_inst_gnt}, 64'd0);
            chk("prio_addr", {32'd0, p_mem_addr}, 64'h600);
            if (i > 0) chk("prio_data_rvalid", {63'd0, p_data_rvalid}, 64'd1);
            next_cyc();
        end
        p_data_req = 1'b0;
        #2;
        chk("prio_inst_gnt_after", {63'd0, p_inst_gnt}, 64'd1);
        chk("prio_data_gnt_after", {63'd0, p_data_gnt}, 64'd0);
        chk("prio_last_data_rvalid", {63'd0, p_data_rvalid}, 64'd1);
        next_cyc();
        p_inst_req = 1'b0; p_mem_gnt = 1'b0;
        #2;
        chk("prio_inst_rvalid", {63'd0, p_inst_rvalid}, 64'd1);
        next_cyc();
        p_mem_rvalid = 1'b0;
        #2;
        chk("prio_cnt", {61'd0, p_outst_cnt}, 64'd0);
        chk("prio_resp_err", {63'd0, p_resp_err}, 64'd0);

        repeat (2) next_cyc();
        chk("gnt_queue_empty", 64'(exp_gnt.size()), 64'd0);
        chk("rsp_queue_empty", 64'(exp_rsp.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
